// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, h/v counters, sync and blank decode.
// Optional VGA_RGB_REG_EN adds a colour register stage with matching sync/blank delay.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_RGB_REG_EN
  ,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
`endif
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   DIV_W    = $clog2(CLK_DIV);
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             running_q, running_d;
  logic             h_wrap, v_wrap;
  logic             hs_raw, vs_raw, blank_raw;

  assign pix_en  = (div_q == DIV_W'(CLK_DIV - 1));
  assign vga_clk = (div_q >= DIV_W'(CLK_DIV / 2));
  assign h_wrap  = (hcnt_q == 10'(H_TOTAL - 1));
  assign v_wrap  = (vcnt_q == 10'(V_TOTAL - 1));

  always_comb begin
    div_d     = pix_en ? '0 : div_q + DIV_W'(1);
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    running_d = 1'b1;
    if (pix_en) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      running_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      running_q <= running_d;
    end
  end

  // Syncs and blank decode straight from the counter flops, so x/y and timing share a cycle.
  assign hs_raw = (hcnt_q >= 10'(H_ACTIVE + H_FP) && hcnt_q < 10'(H_ACTIVE + H_FP + H_SYNC))
                  ? SYNC_ACT : ~SYNC_ACT;
  assign vs_raw = (vcnt_q >= 10'(V_ACTIVE + V_FP) && vcnt_q < 10'(V_ACTIVE + V_FP + V_SYNC))
                  ? SYNC_ACT : ~SYNC_ACT;
  assign blank_raw = running_q && (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign sync_n      = 1'b0;
  assign line_start  = pix_en && (hcnt_q == '0);
  assign frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);

`ifdef VGA_RGB_REG_EN
  logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (pix_en) begin
      hsync_d = hs_raw;
      vsync_d = vs_raw;
      blank_d = blank_raw;
      r_d     = blank_raw ? r_in : 8'h00;
      g_d     = blank_raw ? g_in : 8'h00;
      b_d     = blank_raw ? b_in : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign blank_n = blank_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;
`else
  assign hsync   = hs_raw;
  assign vsync   = vs_raw;
  assign blank_n = blank_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance checked over a line, plus a
// shrunken active-high-sync instance (CLK_DIV=4) checked over whole frames and a mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       d0_pix_en, d0_vga_clk, d0_hsync, d0_vsync, d0_blank_n, d0_sync_n, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y;
  logic       d1_pix_en, d1_vga_clk, d1_hsync, d1_vsync, d1_blank_n, d1_sync_n, d1_ls, d1_fs;
  logic [9:0] d1_x, d1_y;
`ifdef VGA_RGB_REG_EN
  localparam bit DLY = 1'b1;
  logic [7:0] d0_r_in = 8'h00, d0_r, d0_g, d0_b;
  logic [7:0] d1_r, d1_g, d1_b;
`else
  localparam bit DLY = 1'b0;
`endif

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(d0_pix_en), .vga_clk(d0_vga_clk), .x(d0_x), .y(d0_y),
    .hsync(d0_hsync), .vsync(d0_vsync), .blank_n(d0_blank_n), .sync_n(d0_sync_n),
    .line_start(d0_ls), .frame_start(d0_fs)
`ifdef VGA_RGB_REG_EN
    , .r_in(d0_r_in), .g_in(8'h5A), .b_in(8'h00), .r(d0_r), .g(d0_g), .b(d0_b)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(d1_pix_en), .vga_clk(d1_vga_clk), .x(d1_x), .y(d1_y),
    .hsync(d1_hsync), .vsync(d1_vsync), .blank_n(d1_blank_n), .sync_n(d1_sync_n),
    .line_start(d1_ls), .frame_start(d1_fs)
`ifdef VGA_RGB_REG_EN
    , .r_in(8'h00), .g_in(8'h00), .b_in(8'h00), .r(d1_r), .g(d1_g), .b(d1_b)
`endif
  );

  typedef struct packed {
    int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int cdiv; int pol;
  } geom_t;

  geom_t g0 = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, cdiv:2, pol:0};
  geom_t g1 = '{ha:10, hf:2, hs:3, hb:2, va:6, vf:2, vs:2, vb:2, cdiv:4, pol:1};

  // Hand-computed points on the full-size raster; n = clk edges since reset release.
  typedef struct {
    int n; int x; int y; bit pix; bit vclk; bit ls; bit fs; bit hs; bit bl;
  } vec_t;
  localparam int NV = 13;
  vec_t vec[NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
    end
  endtask

  function automatic void pix_at(input geom_t g, input int p, output int px, output int py,
                                 output bit hs, output bit vs, output bit bl);
    int  ht = g.ha + g.hf + g.hs + g.hb;
    int  vt = g.va + g.vf + g.vs + g.vb;
    bit  pol = (g.pol != 0);
    px = p % ht;
    py = (p / ht) % vt;
    hs = (px >= g.ha + g.hf && px < g.ha + g.hf + g.hs) ? pol : !pol;
    vs = (py >= g.va + g.vf && py < g.va + g.vf + g.vs) ? pol : !pol;
    bl = (px < g.ha) && (py < g.va);
  endfunction

  function automatic void model(input geom_t g, input int n, output int ex, output int ey,
                                output bit epix, output bit evclk, output bit els, output bit efs,
                                output bit ehs, output bit evs, output bit ebl);
    int p = n / g.cdiv;
    int dx, dy;
    pix_at(g, p, ex, ey, ehs, evs, ebl);
    ebl   = ebl && (n >= 1);
    epix  = (n % g.cdiv) == g.cdiv - 1;
    evclk = (n % g.cdiv) >= g.cdiv / 2;
    els   = epix && (ex == 0);
    efs   = els && (ey == 0);
    if (DLY) begin
      if (p >= 1) pix_at(g, p - 1, dx, dy, ehs, evs, ebl);
      else begin
        ehs = (g.pol == 0);
        evs = (g.pol == 0);
        ebl = 1'b0;
      end
    end
  endfunction

  function automatic bit rin_hot(input int p);
    return (p % 800 == 5) || (p % 800 == 700);
  endfunction

  task automatic sample(input int n);
    int ex, ey;
    bit epix, evclk, els, efs, ehs, evs, ebl;
    model(g0, n, ex, ey, epix, evclk, els, efs, ehs, evs, ebl);
    check("d0_x", n, d0_x, ex);
    check("d0_y", n, d0_y, ey);
    check("d0_pix_en", n, d0_pix_en, epix);
    check("d0_vga_clk", n, d0_vga_clk, evclk);
    check("d0_line_start", n, d0_ls, els);
    check("d0_frame_start", n, d0_fs, efs);
    check("d0_hsync", n, d0_hsync, ehs);
    check("d0_vsync", n, d0_vsync, evs);
    check("d0_blank_n", n, d0_blank_n, ebl);
    check("d0_sync_n", n, d0_sync_n, 0);
    model(g1, n, ex, ey, epix, evclk, els, efs, ehs, evs, ebl);
    check("d1_x", n, d1_x, ex);
    check("d1_y", n, d1_y, ey);
    check("d1_pix_en", n, d1_pix_en, epix);
    check("d1_vga_clk", n, d1_vga_clk, evclk);
    check("d1_line_start", n, d1_ls, els);
    check("d1_frame_start", n, d1_fs, efs);
    check("d1_hsync", n, d1_hsync, ehs);
    check("d1_vsync", n, d1_vsync, evs);
    check("d1_blank_n", n, d1_blank_n, ebl);
`ifdef VGA_RGB_REG_EN
    begin
      int p = n / 2;
      int qx, qy, er, eg;
      bit qh, qv, qb;
      er = 0;
      eg = 0;
      if (p >= 1) begin
        pix_at(g0, p - 1, qx, qy, qh, qv, qb);
        er = (qb && rin_hot(p - 1)) ? 255 : 0;
        eg = qb ? 'h5A : 0;
      end
      check("d0_r", n, d0_r, er);
      check("d0_g", n, d0_g, eg);
      check("d1_r", n, d1_r, 0);
      d0_r_in = rin_hot(p) ? 8'hFF : 8'h00;
    end
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_d0_x"}, -1, d0_x, 0);
    check({tag, "_d0_y"}, -1, d0_y, 0);
    check({tag, "_d0_hsync"}, -1, d0_hsync, 1);
    check({tag, "_d0_vsync"}, -1, d0_vsync, 1);
    check({tag, "_d0_blank_n"}, -1, d0_blank_n, 0);
    check({tag, "_d0_pix_en"}, -1, d0_pix_en, 0);
    check({tag, "_d0_vga_clk"}, -1, d0_vga_clk, 0);
    check({tag, "_d0_line_start"}, -1, d0_ls, 0);
    check({tag, "_d0_frame_start"}, -1, d0_fs, 0);
    check({tag, "_d0_sync_n"}, -1, d0_sync_n, 0);
    check({tag, "_d1_x"}, -1, d1_x, 0);
    check({tag, "_d1_y"}, -1, d1_y, 0);
    check({tag, "_d1_hsync"}, -1, d1_hsync, 0);
    check({tag, "_d1_vsync"}, -1, d1_vsync, 0);
    check({tag, "_d1_pix_en"}, -1, d1_pix_en, 0);
    check({tag, "_d1_vga_clk"}, -1, d1_vga_clk, 0);
`ifdef VGA_RGB_REG_EN
    check({tag, "_d0_r"}, -1, d0_r, 0);
    check({tag, "_d0_g"}, -1, d0_g, 0);
`endif
  endtask

  // Called right after rst_n is released at a falling edge; walks nmax clk edges.
  task automatic run_pass(input int nmax);
    int ti = 0;
    int h0_low = 0, ls0 = 0, fs0 = 0;
    int ls1 = 0, fs1 = 0, vs1 = 0, hs1 = 0, bl1 = 0;
    for (int n = 0; n <= nmax; n++) begin
      if (n > 0) @(negedge clk);
      if (ti < NV && vec[ti].n == n) begin
        check("tbl_x", n, d0_x, vec[ti].x);
        check("tbl_y", n, d0_y, vec[ti].y);
        check("tbl_pix_en", n, d0_pix_en, vec[ti].pix);
        check("tbl_vga_clk", n, d0_vga_clk, vec[ti].vclk);
        check("tbl_line_start", n, d0_ls, vec[ti].ls);
        check("tbl_frame_start", n, d0_fs, vec[ti].fs);
`ifndef VGA_RGB_REG_EN
        check("tbl_hsync", n, d0_hsync, vec[ti].hs);
        check("tbl_blank_n", n, d0_blank_n, vec[ti].bl);
`endif
        ti++;
      end
      sample(n);
      if (n >= 1 && n <= 1600) begin
        if (!d0_hsync) h0_low++;
        if (d0_ls) ls0++;
        if (d0_fs) fs0++;
      end
      if (n >= 1 && n <= 816) begin
        if (d1_ls) ls1++;
        if (d1_fs) fs1++;
        if (d1_vsync) vs1++;
        if (d1_hsync) hs1++;
        if (d1_blank_n) bl1++;
      end
    end
    check("d0_hsync_low_clks", -1, h0_low, 192);
    check("d0_line_starts_per_line", -1, ls0, 1);
    check("d0_frame_starts_per_line", -1, fs0, 1);
    check("d1_line_starts_per_frame", -1, ls1, 12);
    check("d1_frame_starts_per_frame", -1, fs1, 1);
    check("d1_vsync_active_clks", -1, vs1, 136);
    check("d1_hsync_active_clks", -1, hs1, 144);
    check("d1_blank_n_high_clks", -1, bl1, 240);
  endtask

  initial begin
    vec[0]  = '{n:0,    x:0,   y:0, pix:0, vclk:0, ls:0, fs:0, hs:1, bl:0};
    vec[1]  = '{n:1,    x:0,   y:0, pix:1, vclk:1, ls:1, fs:1, hs:1, bl:1};
    vec[2]  = '{n:2,    x:1,   y:0, pix:0, vclk:0, ls:0, fs:0, hs:1, bl:1};
    vec[3]  = '{n:3,    x:1,   y:0, pix:1, vclk:1, ls:0, fs:0, hs:1, bl:1};
    vec[4]  = '{n:1279, x:639, y:0, pix:1, vclk:1, ls:0, fs:0, hs:1, bl:1};
    vec[5]  = '{n:1280, x:640, y:0, pix:0, vclk:0, ls:0, fs:0, hs:1, bl:0};
    vec[6]  = '{n:1311, x:655, y:0, pix:1, vclk:1, ls:0, fs:0, hs:1, bl:0};
    vec[7]  = '{n:1312, x:656, y:0, pix:0, vclk:0, ls:0, fs:0, hs:0, bl:0};
    vec[8]  = '{n:1503, x:751, y:0, pix:1, vclk:1, ls:0, fs:0, hs:0, bl:0};
    vec[9]  = '{n:1504, x:752, y:0, pix:0, vclk:0, ls:0, fs:0, hs:1, bl:0};
    vec[10] = '{n:1599, x:799, y:0, pix:1, vclk:1, ls:0, fs:0, hs:1, bl:0};
    vec[11] = '{n:1600, x:0,   y:1, pix:0, vclk:0, ls:0, fs:0, hs:1, bl:1};
    vec[12] = '{n:1601, x:0,   y:1, pix:1, vclk:1, ls:1, fs:0, hs:1, bl:1};

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset("hold");
    end
    rst_n = 1'b1;
    // Walk to the point where dut1 sits at x=5,y=8 inside vsync and dut0 at x=299,y=1.
    run_pass(2199);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
`ifdef VGA_RGB_REG_EN
    d0_r_in = 8'h00;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset("rehold");
    end
    rst_n = 1'b1;
    run_pass(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
